// File: rtl/lu_response_checker_pkg.sv
// lu_response_checker_pkg
//   Shared definitions for the logic-unit response checker:
//   - LU_AND/LU_OR/LU_NOR/LU_XOR : operation codes carried on 'control'
//   - state_t                    : checker FSM state encoding
package lu_response_checker_pkg;

  localparam logic [1:0] LU_AND = 2'd0;
  localparam logic [1:0] LU_OR  = 2'd1;
  localparam logic [1:0] LU_NOR = 2'd2;
  localparam logic [1:0] LU_XOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lu_ref_model.sv
// lu_ref_model
//   Combinational golden model of the logic unit under test.
//   Ports:
//     A, B     : operands (WIDTH bits)
//     control  : operation select (LU_AND, LU_OR, LU_NOR, LU_XOR)
//     expected : correct result (WIDTH bits)
module lu_ref_model
  import lu_response_checker_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] expected
);

  always_comb begin
    expected = '0;
    case (control)
      LU_AND:  expected = A & B;
      LU_OR:   expected = A | B;
      LU_NOR:  expected = ~(A | B);
      LU_XOR:  expected = A ^ B;
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/lu_response_checker.sv
// lu_response_checker
//   Watches a logic unit's operands, operation select and response, compares
//   the response against lu_ref_model and accumulates a run report.
//   Optional feature: define LU_CHECKER_FIRST_ERR_EN to capture the first
//   mismatch of a run into first_err_*; otherwise those ports read 0.
//   Ports:
//     clock, reset        : clock and synchronous active-high reset
//     start               : one-cycle pulse, begins (or restarts) a run
//     valid               : qualifies A/B/control/out for this cycle
//     A, B, control, out  : sampled stimulus and response of the unit
//     busy / done / pass  : run in progress / run finished / finished clean
//     err_count           : mismatches this run, saturating at 16'hFFFF
//     coverage            : bit {control,A[0],B[0]} set once seen
//     first_err_*         : control/A/B/out of the first mismatch
module lu_response_checker
  import lu_response_checker_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int NUM_SAMPLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      coverage,
  output logic [1:0]       first_err_ctl,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_out
);

  // Counter value held just before the final sample is taken.
  localparam logic [15:0] LAST_SAMPLE = 16'(NUM_SAMPLES - 1);

  state_t           state_reg, state_next;
  logic [15:0]      sample_count_reg;
  logic [15:0]      err_count_reg;
  logic [15:0]      coverage_reg;
  logic [WIDTH-1:0] expected;
  logic             sample_take;
  logic             mismatch;
  logic             clear_run;
  logic [3:0]       cov_index;
  logic [15:0]      cov_hit;

  lu_ref_model #(.WIDTH(WIDTH)) u_ref_model (
    .A        (A),
    .B        (B),
    .control  (control),
    .expected (expected)
  );

  // start is honoured from IDLE and DONE only; valid only counts in RUN,
  // so a start+valid coincidence on the launch edge is not a sample.
  assign clear_run   = start && (state_reg != RUN);
  assign sample_take = valid && (state_reg == RUN);
  assign mismatch    = (out != expected);
  assign cov_index   = {control, A[0], B[0]};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cov
      assign cov_hit[gi] = sample_take && (cov_index == 4'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (sample_take && (sample_count_reg == LAST_SAMPLE)) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      sample_count_reg <= '0;
      err_count_reg    <= '0;
      coverage_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (clear_run) begin
        sample_count_reg <= '0;
        err_count_reg    <= '0;
        coverage_reg     <= '0;
      end else if (sample_take) begin
        if (sample_count_reg != 16'hFFFF) sample_count_reg <= sample_count_reg + 16'd1;
        if (mismatch && (err_count_reg != 16'hFFFF)) err_count_reg <= err_count_reg + 16'd1;
        coverage_reg <= coverage_reg | cov_hit;
      end
    end
  end

`ifdef LU_CHECKER_FIRST_ERR_EN
  logic [1:0]       first_err_ctl_reg;
  logic [WIDTH-1:0] first_err_a_reg;
  logic [WIDTH-1:0] first_err_b_reg;
  logic [WIDTH-1:0] first_err_out_reg;

  // A zero error count means no mismatch has been captured yet this run.
  always_ff @(posedge clock) begin
    if (reset || clear_run) begin
      first_err_ctl_reg <= '0;
      first_err_a_reg   <= '0;
      first_err_b_reg   <= '0;
      first_err_out_reg <= '0;
    end else if (sample_take && mismatch && (err_count_reg == 16'd0)) begin
      first_err_ctl_reg <= control;
      first_err_a_reg   <= A;
      first_err_b_reg   <= B;
      first_err_out_reg <= out;
    end
  end

  assign first_err_ctl = first_err_ctl_reg;
  assign first_err_a   = first_err_a_reg;
  assign first_err_b   = first_err_b_reg;
  assign first_err_out = first_err_out_reg;
`else
  assign first_err_ctl = '0;
  assign first_err_a   = '0;
  assign first_err_b   = '0;
  assign first_err_out = '0;
`endif

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign pass      = done && (err_count_reg == 16'd0);
  assign err_count = err_count_reg;
  assign coverage  = coverage_reg;

endmodule

// File: doc/lu_response_checker.md
LU_RESPONSE_CHECKER -- requirements
Module: lu_response_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, giving the operand and result width.
REQ-002 The module SHALL have parameter NUM_SAMPLES, default 16, giving the number of valid samples per run; the legal range is 1..65535.
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit, a one-cycle pulse that begins a run.
REQ-006 The module SHALL have port valid, input, 1 bit, which qualifies the current A/B/control/out sample.
REQ-007 The module SHALL have ports A and B, input, WIDTH bits each, the operands applied to the logic unit under test.
REQ-008 The module SHALL have port control, input, 2 bits, the operation select applied to the unit under test.
REQ-009 The module SHALL have port out, input, WIDTH bits, the response of the unit under test.
REQ-010 The module SHALL have port busy, output, 1 bit, high in RUN.
REQ-011 The module SHALL have port done, output, 1 bit, high in DONE.
REQ-012 The module SHALL have port pass, output, 1 bit, high in DONE when err_count is 0.
REQ-013 The module SHALL have port err_count, output, 16 bits, the number of mismatches in the current run.
REQ-014 The module SHALL have port coverage, output, 16 bits; bit {control,A[0],B[0]} is set once that combination has been sampled.
REQ-015 The module SHALL have ports first_err_ctl (2 bits), first_err_a, first_err_b and first_err_out (WIDTH bits each), all outputs, holding details of the first mismatch.

Function
REQ-016 The expected result SHALL be: control 0 gives A&B; 1 gives A|B; 2 gives ~(A|B); 3 gives A^B; the comparison is bitwise over all WIDTH bits.
REQ-017 The FSM SHALL have three states, IDLE, RUN and DONE; reset enters IDLE.
REQ-018 The FSM SHALL go from IDLE to RUN on start; the same edge clears err_count, the sample counter, coverage and the first-error registers.
REQ-019 In RUN, each edge with valid high SHALL count one sample, set one coverage bit and, on mismatch, increment err_count.
REQ-020 Latency: the effect of a sample SHALL be visible on outputs in the cycle after the sampling edge.
REQ-021 The edge that takes sample NUM_SAMPLES SHALL also move the FSM to DONE, so done rises in the following cycle.
REQ-022 valid SHALL be ignored in IDLE and DONE.
REQ-023 start SHALL be ignored in RUN.
REQ-024 start in DONE SHALL restart exactly as IDLE->RUN does (REQ-018).
REQ-025 When start and valid coincide on the IDLE->RUN edge, the sample SHALL NOT be counted.
REQ-026 err_count SHALL saturate at 16'hFFFF.
REQ-027 The sample counter SHALL be 16 bits and SHALL never wrap within a run.
REQ-028 Outputs SHALL hold their values in DONE until the next start or reset.

Reset
REQ-029 When reset is high at an edge, the next state SHALL be IDLE with busy=0, done=0, pass=0, err_count=0, coverage=0 and all first_err_* ports 0.
REQ-030 Reset SHALL take priority over start and valid, including mid-run; the partial run is discarded.

Configuration
REQ-031 With macro LU_CHECKER_FIRST_ERR_EN defined, the first mismatch of a run SHALL capture control, A, B and out into first_err_*, which then hold until restart or reset.
REQ-032 Without LU_CHECKER_FIRST_ERR_EN, the first_err_* ports SHALL still exist, be tied to 0 and have no capture registers; all other behaviour is unchanged.

Structure
REQ-033 A shared package SHALL hold the constants LU_AND=0, LU_OR=1, LU_NOR=2, LU_XOR=3 and the state encodings IDLE=0, RUN=1, DONE=2.
REQ-034 The expected-result function SHALL be a combinational sub-module lu_ref_model (ports A, B, control, expected), instantiated once.

Verification
REQ-035 The bench SHALL cover a correct DUT: with WIDTH=1 and NUM_SAMPLES=16, all 16 {control,A,B} combinations applied -> done=1, pass=1, err_count=0, coverage=16'hFFFF.
REQ-036 The bench SHALL cover an injected fault: out inverted only on control=2, A=1, B=0 -> err_count=1, pass=0, and with the macro first_err_ctl=2, a=1, b=0, out=1.
REQ-037 The bench SHALL cover saturation: NUM_SAMPLES=65535 with every sample wrong -> err_count=16'hFFFF, with no wrap.
REQ-038 The bench SHALL cover reset mid-run: reset after 5 samples -> next cycle IDLE, err_count=0, coverage=0; valid is then ignored until start.
REQ-039 The bench SHALL cover handshake edges: start together with valid is not counted; start in RUN is ignored; start in DONE clears counters, and busy=1 in the next cycle.
REQ-040 The bench SHALL cover the macro off: the same fault as REQ-036 -> err_count=1, and all first_err_* stay 0.
